uart_rx_cfg: RTL and testbench

UART_RX_CFG -- requirements
Module: uart_rx_cfg

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_rx_sync.sv | 26 ++
 rtl/uart_rx_cfg.sv | 225 ++++++++++++++++++++++
 tb/tb_uart_rx_cfg.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the configurable UART receiver.
//   - Parity-mode encodings for the PARITY parameter.
//   - FSM state encoding (plain localparams so legacy code can reuse them).
//   - maj3(): majority vote over three line samples.
package uart_pkg;

    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_ODD  = 1;
    localparam int unsigned PAR_EVEN = 2;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_START     = 3'd1;
    localparam logic [2:0] ST_DATA      = 3'd2;
    localparam logic [2:0] ST_PARITY    = 3'd3;
    localparam logic [2:0] ST_STOP      = 3'd4;
    localparam logic [2:0] ST_WAIT_IDLE = 3'd5;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous serial line.
// Ports:
//   clk  - clock
//   rst  - synchronous active-high reset; both flops preset to 1 (idle line)
//   d    - asynchronous input
//   q    - synchronised output
module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [1:0] ff_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ff_q <= 2'b11;
        end else begin
            ff_q <= {ff_q[0], d};
        end
    end

    assign q = ff_q[1];

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver with majority-vote bit sampling.
// Parameters:
//   CLKS_PER_BIT - clock cycles per bit period (>= 8)
//   DATA_BITS    - data bits per frame (5..9)
//   PARITY       - PAR_NONE / PAR_ODD / PAR_EVEN
//   STOP_BITS    - stop bits per frame (1 or 2)
// Ports:
//   clk         - clock, rising edge
//   rst         - synchronous active-high reset
//   RX          - asynchronous serial input, idle high
//   en_data_out - one-cycle pulse when a frame completes (also on error)
//   data_out    - received word, LSB first on the line; held until next pulse
//   parity_err  - parity mismatch, valid with en_data_out
//   frame_err   - a stop bit was sampled low, valid with en_data_out
//   busy        - FSM is not idle
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 5000,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned PARITY       = 0,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 RX,
    output logic                 en_data_out,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int unsigned TW = $clog2(CLKS_PER_BIT);
    localparam int unsigned CW = $clog2(DATA_BITS + 1);

    localparam logic [TW-1:0] T_LAST   = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] T_MID_M1 = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] T_MID    = TW'(CLKS_PER_BIT / 2);
    localparam logic [TW-1:0] T_MID_P1 = TW'(CLKS_PER_BIT / 2 + 1);

    localparam logic [CW-1:0] C_DATA_LAST = CW'(DATA_BITS - 1);
    localparam logic [CW-1:0] C_STOP_LAST = CW'(STOP_BITS - 1);

    // Synchronised line and its previous value for falling-edge detection.
    logic rxs;
    logic rxs_q;

    logic [2:0]           state_q, state_d;
    logic [TW-1:0]        timer_q, timer_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [1:0]           samp_q, samp_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 par_bit_q, par_bit_d;
    logic                 fe_q, fe_d;

    logic                 en_q, en_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 perr_q, perr_d;
    logic                 ferr_q, ferr_d;

    logic timing;
    logic vote_now;
    logic vote;
    logic par_x;
    logic perr_calc;
    logic fe_next;

    uart_rx_sync u_sync (
        .clk (clk),
        .rst (rst),
        .d   (RX),
        .q   (rxs)
    );

    // Bit timer only runs while a frame is being sampled.
    assign timing = (state_q == ST_START) || (state_q == ST_DATA) ||
                    (state_q == ST_PARITY) || (state_q == ST_STOP);

    // The third sample is the current rxs, so the vote resolves at mid+1.
    assign vote_now = timing && (timer_q == T_MID_P1);
    assign vote     = maj3(samp_q[0], samp_q[1], rxs);

    assign par_x   = (^shreg_q) ^ par_bit_q;
    assign fe_next = fe_q | ~vote;

    always_comb begin
        perr_calc = 1'b0;
        if (PARITY == PAR_ODD) begin
            perr_calc = ~par_x;
        end else if (PARITY == PAR_EVEN) begin
            perr_calc = par_x;
        end
    end

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        cnt_d     = cnt_q;
        samp_d    = samp_q;
        shreg_d   = shreg_q;
        par_bit_d = par_bit_q;
        fe_d      = fe_q;
        en_d      = 1'b0;
        data_d    = data_q;
        perr_d    = perr_q;
        ferr_d    = ferr_q;

        // Wrapping the timer modulo CLKS_PER_BIT spaces successive mid
        // samples exactly one bit period apart.
        if (timing) begin
            timer_d = (timer_q == T_LAST) ? '0 : timer_q + TW'(1);
            if (timer_q == T_MID_M1) begin
                samp_d[0] = rxs;
            end
            if (timer_q == T_MID) begin
                samp_d[1] = rxs;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (rxs_q && !rxs) begin
                    state_d = ST_START;
                    timer_d = '0;
                end
            end
            ST_START: begin
                if (vote_now) begin
                    if (vote) begin
                        // Glitch: start bit did not hold low at mid-bit.
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_DATA;
                        cnt_d   = '0;
                        fe_d    = 1'b0;
                    end
                end
            end
            ST_DATA: begin
                if (vote_now) begin
                    shreg_d = {vote, shreg_q[DATA_BITS-1:1]};
                    if (cnt_q == C_DATA_LAST) begin
                        cnt_d   = '0;
                        state_d = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            ST_PARITY: begin
                if (vote_now) begin
                    par_bit_d = vote;
                    state_d   = ST_STOP;
                end
            end
            ST_STOP: begin
                if (vote_now) begin
                    if (cnt_q == C_STOP_LAST) begin
                        en_d    = 1'b1;
                        data_d  = shreg_q;
                        perr_d  = perr_calc;
                        ferr_d  = fe_next;
                        cnt_d   = '0;
                        // After a bad stop bit the line may be in break;
                        // wait for it to go high before arming edge detect.
                        state_d = fe_next ? ST_WAIT_IDLE : ST_IDLE;
                    end else begin
                        fe_d  = fe_next;
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            ST_WAIT_IDLE: begin
                if (rxs) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if ((state_d == ST_IDLE) || (state_d == ST_WAIT_IDLE)) begin
            timer_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rxs_q     <= 1'b1;
            state_q   <= ST_IDLE;
            timer_q   <= '0;
            cnt_q     <= '0;
            samp_q    <= 2'b11;
            shreg_q   <= '0;
            par_bit_q <= 1'b0;
            fe_q      <= 1'b0;
            en_q      <= 1'b0;
            data_q    <= '0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            rxs_q     <= rxs;
            state_q   <= state_d;
            timer_q   <= timer_d;
            cnt_q     <= cnt_d;
            samp_q    <= samp_d;
            shreg_q   <= shreg_d;
            par_bit_q <= par_bit_d;
            fe_q      <= fe_d;
            en_q      <= en_d;
            data_q    <= data_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
        end
    end

    assign en_data_out = en_q;
    assign data_out    = data_q;
    assign parity_err  = perr_q;
    assign frame_err   = ferr_q;
    assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: four instances with different parameter sets.
// The default-rate instance runs in parallel with the 16-cycle instances.
module tb_uart_rx_cfg;

    localparam int BIT = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- instances ----------------
    logic       rx_def, rst_def, en_def, pe_def, fe_def, busy_def;
    logic [7:0] d_def;
    logic       rx_par, rst_par, en_par, pe_par, fe_par, busy_par;
    logic [7:0] d_par;
    logic       rx_c16, rst_c16, en_c16, pe_c16, fe_c16, busy_c16;
    logic [7:0] d_c16;
    logic       rx_b2b, rst_b2b, en_b2b, pe_b2b, fe_b2b, busy_b2b;
    logic [4:0] d_b2b;

    uart_rx_cfg u_def (
        .clk(clk), .rst(rst_def), .RX(rx_def), .en_data_out(en_def), .data_out(d_def),
        .parity_err(pe_def), .frame_err(fe_def), .busy(busy_def)
    );

    uart_rx_cfg #(.CLKS_PER_BIT(BIT), .PARITY(2)) u_par (
        .clk(clk), .rst(rst_par), .RX(rx_par), .en_data_out(en_par), .data_out(d_par),
        .parity_err(pe_par), .frame_err(fe_par), .busy(busy_par)
    );

    uart_rx_cfg #(.CLKS_PER_BIT(BIT)) u_c16 (
        .clk(clk), .rst(rst_c16), .RX(rx_c16), .en_data_out(en_c16), .data_out(d_c16),
        .parity_err(pe_c16), .frame_err(fe_c16), .busy(busy_c16)
    );

    uart_rx_cfg #(.CLKS_PER_BIT(BIT), .DATA_BITS(5), .STOP_BITS(2)) u_b2b (
        .clk(clk), .rst(rst_b2b), .RX(rx_b2b), .en_data_out(en_b2b), .data_out(d_b2b),
        .parity_err(pe_b2b), .frame_err(fe_b2b), .busy(busy_b2b)
    );

    // ---------------- pulse monitors ----------------
    int cnt_def = 0, cnt_par = 0, cnt_c16 = 0, cnt_b2b = 0;
    int dbl_def = 0, dbl_par = 0, dbl_c16 = 0, dbl_b2b = 0;
    int busy_cyc_c16 = 0;
    int flag_or_b2b = 0;
    logic ep_def = 1'b0, ep_par = 1'b0, ep_c16 = 1'b0, ep_b2b = 1'b0;
    logic [4:0] log_b2b [0:3];

    always @(posedge clk) begin
        ep_def <= en_def;
        if (en_def) cnt_def <= cnt_def + 1;
        if (en_def && ep_def) dbl_def <= dbl_def + 1;
    end

    always @(posedge clk) begin
        ep_par <= en_par;
        if (en_par) cnt_par <= cnt_par + 1;
        if (en_par && ep_par) dbl_par <= dbl_par + 1;
    end

    always @(posedge clk) begin
        ep_c16 <= en_c16;
        if (en_c16) cnt_c16 <= cnt_c16 + 1;
        if (en_c16 && ep_c16) dbl_c16 <= dbl_c16 + 1;
        if (busy_c16) busy_cyc_c16 <= busy_cyc_c16 + 1;
    end

    always @(posedge clk) begin
        ep_b2b <= en_b2b;
        if (en_b2b) begin
            cnt_b2b <= cnt_b2b + 1;
            if (cnt_b2b < 4) log_b2b[cnt_b2b] <= d_b2b;
            if (pe_b2b || fe_b2b) flag_or_b2b <= flag_or_b2b + 1;
        end
        if (en_b2b && ep_b2b) dbl_b2b <= dbl_b2b + 1;
    end

    // ---------------- stimulus helpers (16-cycle instances) ----------------
    task automatic drive(input int which, input logic v);
        case (which)
            1: rx_par = v;
            2: rx_c16 = v;
            default: rx_b2b = v;
        endcase
    endtask

    task automatic hold(input int which, input logic v, input int cycles);
        drive(which, v);
        repeat (cycles) @(negedge clk);
    endtask

    // par_bit < 0 means no parity bit; only the first nsend bits go out.
    task automatic send_frame(input int which, input logic [8:0] data, input int ndata,
                              input int par_bit, input int nstop, input logic stop_val,
                              input int nsend);
        logic [15:0] fr;
        int n;
        fr = '0;
        n  = 1;
        for (int i = 0; i < ndata; i++) begin
            fr[n] = data[i];
            n++;
        end
        if (par_bit >= 0) begin
            fr[n] = par_bit[0];
            n++;
        end
        for (int i = 0; i < nstop; i++) begin
            fr[n] = stop_val;
            n++;
        end
        for (int i = 0; i < n && i < nsend; i++) begin
            hold(which, fr[i], BIT);
        end
    endtask

    // ---------------- default-parameter run ----------------
    task automatic run_default();
        logic [9:0] fr;
        rx_def  = 1'b1;
        rst_def = 1'b1;
        repeat (3) @(negedge clk);
        rst_def = 1'b0;
        @(negedge clk);
        check("def_rst_en", 32'(en_def), 32'h0);
        check("def_rst_data", 32'(d_def), 32'h0);
        check("def_rst_busy", 32'(busy_def), 32'h0);
        fr = {1'b1, 8'hAA, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx_def = fr[i];
            repeat (5000) @(negedge clk);
        end
        rx_def = 1'b1;
        repeat (10000) @(negedge clk);
        check("def_pulses", 32'(cnt_def), 32'd1);
        check("def_data", 32'(d_def), 32'hAA);
        check("def_perr", 32'(pe_def), 32'h0);
        check("def_ferr", 32'(fe_def), 32'h0);
        check("def_busy_idle", 32'(busy_def), 32'h0);
    endtask

    // ---------------- 16-cycle-per-bit runs ----------------
    task automatic run_cfg();
        int b0;
        rx_par = 1'b1; rx_c16 = 1'b1; rx_b2b = 1'b1;
        rst_par = 1'b1; rst_c16 = 1'b1; rst_b2b = 1'b1;
        repeat (3) @(negedge clk);
        rst_par = 1'b0; rst_c16 = 1'b0; rst_b2b = 1'b0;
        @(negedge clk);
        check("rst_en", 32'(en_c16), 32'h0);
        check("rst_data", 32'(d_c16), 32'h0);
        check("rst_perr", 32'(pe_c16), 32'h0);
        check("rst_ferr", 32'(fe_c16), 32'h0);
        check("rst_busy", 32'(busy_c16), 32'h0);

        // Even parity: 0x55 has four ones, so parity bit 0 is correct.
        send_frame(1, 9'h055, 8, 0, 1, 1'b1, 99);
        hold(1, 1'b1, BIT);
        check("par_ok_pulses", 32'(cnt_par), 32'd1);
        check("par_ok_data", 32'(d_par), 32'h55);
        check("par_ok_perr", 32'(pe_par), 32'h0);
        check("par_ok_ferr", 32'(fe_par), 32'h0);
        send_frame(1, 9'h055, 8, 1, 1, 1'b1, 99);
        hold(1, 1'b1, BIT);
        check("par_bad_pulses", 32'(cnt_par), 32'd2);
        check("par_bad_data", 32'(d_par), 32'h55);
        check("par_bad_perr", 32'(pe_par), 32'h1);

        // Stop bit low, then break for 40 bit times.
        send_frame(2, 9'h03C, 8, -1, 1, 1'b0, 99);
        hold(2, 1'b0, 40 * BIT);
        check("brk_pulses", 32'(cnt_c16), 32'd1);
        check("brk_ferr", 32'(fe_c16), 32'h1);
        check("brk_data", 32'(d_c16), 32'h3C);
        check("brk_perr", 32'(pe_c16), 32'h0);
        check("brk_busy_wait", 32'(busy_c16), 32'h1);
        hold(2, 1'b1, 2 * BIT);
        check("brk_busy_released", 32'(busy_c16), 32'h0);
        check("brk_no_extra", 32'(cnt_c16), 32'd1);
        send_frame(2, 9'h081, 8, -1, 1, 1'b1, 99);
        hold(2, 1'b1, BIT);
        check("brk_next_pulses", 32'(cnt_c16), 32'd2);
        check("brk_next_data", 32'(d_c16), 32'h81);
        check("brk_next_ferr", 32'(fe_c16), 32'h0);

        // Short low glitch.
        b0 = busy_cyc_c16;
        hold(2, 1'b0, 6);
        hold(2, 1'b1, 16);
        check("glitch_busy_seen", 32'(busy_cyc_c16 != b0), 32'h1);
        check("glitch_busy_clear", 32'(busy_c16), 32'h0);
        hold(2, 1'b1, BIT);
        check("glitch_no_pulse", 32'(cnt_c16), 32'd2);
        check("glitch_data_kept", 32'(d_c16), 32'h81);

        // Reset during data bit 4 of 0xA5 (bit 4 is 0).
        send_frame(2, 9'h0A5, 8, -1, 1, 1'b1, 5);
        hold(2, 1'b0, 8);
        rst_c16 = 1'b1;
        repeat (2) @(negedge clk);
        drive(2, 1'b1);
        @(negedge clk);
        rst_c16 = 1'b0;
        hold(2, 1'b1, 2 * BIT);
        check("mrst_no_pulse", 32'(cnt_c16), 32'd2);
        check("mrst_data", 32'(d_c16), 32'h0);
        check("mrst_perr", 32'(pe_c16), 32'h0);
        check("mrst_ferr", 32'(fe_c16), 32'h0);
        check("mrst_busy", 32'(busy_c16), 32'h0);
        send_frame(2, 9'h05A, 8, -1, 1, 1'b1, 99);
        hold(2, 1'b1, BIT);
        check("mrst_next_pulses", 32'(cnt_c16), 32'd3);
        check("mrst_next_data", 32'(d_c16), 32'h5A);

        // Back-to-back 5-bit frames with two stop bits.
        send_frame(3, 9'h01F, 5, -1, 2, 1'b1, 99);
        send_frame(3, 9'h00A, 5, -1, 2, 1'b1, 99);
        hold(3, 1'b1, 2 * BIT);
        check("b2b_pulses", 32'(cnt_b2b), 32'd2);
        check("b2b_first", 32'(log_b2b[0]), 32'h1F);
        check("b2b_second", 32'(log_b2b[1]), 32'h0A);
        check("b2b_flags", 32'(flag_or_b2b), 32'd0);
        check("b2b_data_held", 32'(d_b2b), 32'h0A);
    endtask

    initial begin
        fork
            run_default();
            run_cfg();
        join
        check("pulse_width_def", 32'(dbl_def), 32'd0);
        check("pulse_width_par", 32'(dbl_par), 32'd0);
        check("pulse_width_c16", 32'(dbl_c16), 32'd0);
        check("pulse_width_b2b", 32'(dbl_b2b), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

endmodule
